// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared I/O map and read-source type for mem_responder
package mem_responder_pkg;

   localparam logic [17:0] IO_BASE = 18'h30000;
   localparam logic [15:0] IO_DATA = 16'h0000;
   localparam logic [15:0] IO_CLK  = 16'h0004;

   typedef enum logic {
      SRC_RAM = 1'b0,
      SRC_IO  = 1'b1
   } rd_src_e;

   function automatic logic is_io(input logic [17:0] addr);
      return addr[17:16] == IO_BASE[17:16];
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU byte bus plus rx/tx byte ports seen by mem_responder
interface mem_responder_if;

   logic        rdy;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        halt;

   modport master (
      output rdy, mem_a, mem_dout, mem_wr, rx_data, rx_valid,
      input  mem_din, rx_ready, tx_data, tx_valid, halt
   );

   modport slave (
      input  rdy, mem_a, mem_dout, mem_wr, rx_data, rx_valid,
      output mem_din, rx_ready, tx_data, tx_valid, halt
   );

endinterface

// File: rtl/mem_responder_rx_fifo.sv
// rtl/mem_responder_rx_fifo.sv - synchronous byte FIFO holding host input bytes
module mem_responder_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - block RAM plus byte I/O, cycle counter and stop strobe behind the CPU bus
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int RAM_AW   = 17,
   parameter int RX_DEPTH = 16
) (
   input logic              clk,
   input logic              rst,
   mem_responder_if.slave   bus
);

   logic [17:0]       addr;
   logic [15:0]       io_off;
   logic              io_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic              rd_en, wr_en;
   logic              unused_addr_hi;

   assign addr           = bus.mem_a[17:0];
   assign io_off         = addr[15:0];
   assign io_sel         = is_io(addr);
   assign ram_idx        = bus.mem_a[RAM_AW-1:0];
   assign rd_en          = bus.rdy && !bus.mem_wr;
   assign wr_en          = bus.rdy && bus.mem_wr;
   assign unused_addr_hi = ^bus.mem_a[31:18];

   logic [7:0] ram [2**RAM_AW];
   logic [7:0] ram_rd_q;

   // Kept free of reset and muxing so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en && !io_sel) ram[ram_idx] <= bus.mem_dout;
      if (rd_en && !io_sel) ram_rd_q <= ram[ram_idx];
   end

   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dout;

   mem_responder_rx_fifo #(.DEPTH(RX_DEPTH), .W(8)) rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.rx_valid && bus.rx_ready),
      .pop   (fifo_pop),
      .din   (bus.rx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.rx_ready = !fifo_full;

   rd_src_e     src_q, src_d;
   logic [7:0]  io_rd_q, io_rd_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        halt_q, halt_d;

   always_comb begin
      src_d      = src_q;
      io_rd_d    = io_rd_q;
      snap_d     = snap_q;
      cnt_d      = cnt_q + 32'd1;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      halt_d     = halt_q;
      fifo_pop   = 1'b0;

      if (rd_en) begin
         src_d   = io_sel ? SRC_IO : SRC_RAM;
         io_rd_d = 8'h00;
         if (io_sel) begin
            if (io_off == IO_DATA) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  io_rd_d  = fifo_dout;
               end
            end else if (io_off[15:2] == IO_CLK[15:2]) begin
               // Byte 0 latches the snapshot so bytes 1..3 stay coherent with it.
               case (io_off[1:0])
                  2'd0: begin
                     snap_d  = cnt_q;
                     io_rd_d = cnt_q[7:0];
                  end
                  2'd1:    io_rd_d = snap_q[15:8];
                  2'd2:    io_rd_d = snap_q[23:16];
                  default: io_rd_d = snap_q[31:24];
               endcase
            end
         end
      end

      if (wr_en && io_sel) begin
         if (io_off == IO_DATA) begin
            if (bus.mem_dout != 8'h00) begin
               tx_data_d  = bus.mem_dout;
               tx_valid_d = 1'b1;
            end
         end else if (io_off == IO_CLK) begin
            halt_d     = 1'b1;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         src_q      <= SRC_IO;
         io_rd_q    <= 8'h00;
         snap_q     <= 32'h0;
         cnt_q      <= 32'h0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         src_q      <= src_d;
         io_rd_q    <= io_rd_d;
         snap_q     <= snap_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         halt_q     <= halt_d;
      end
   end

   assign bus.mem_din  = (src_q == SRC_IO) ? io_rd_q : ram_rd_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.halt     = halt_q;

endmodule
